// File: rtl/mux_pc.sv
// Next-PC source selector with a registered copy of the chosen PC.
// Combinational priority mux (jump > jalr > branch > pc+4) plus an enable-gated PC register.
module mux_pc #(
  parameter int NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_Jump,
  input  logic             i_JALR,
  input  logic [NBITS-1:0] i_rs,
  input  logic             i_pcSrc,
  input  logic [NBITS-1:0] i_SumadorBranch,
  input  logic [NBITS-1:0] i_sumador_pc4,
  input  logic [NBITS-1:0] i_SumadorJump,
  input  logic             i_enable,
  output logic [NBITS-1:0] o_pc,
  output logic [NBITS-1:0] o_pc_q,
  output logic [1:0]       o_sel
);

  localparam logic [1:0] SEL_PC4    = 2'd0;
  localparam logic [1:0] SEL_BRANCH = 2'd1;
  localparam logic [1:0] SEL_JALR   = 2'd2;
  localparam logic [1:0] SEL_JUMP   = 2'd3;

  logic [NBITS-1:0] w_pc;
  logic [1:0]       w_sel;
  logic [NBITS-1:0] r_pc_q;

  // The address and its source code are produced by the same branch of the
  // priority chain, so they can never disagree.
  always_comb begin
    w_pc  = i_sumador_pc4;
    w_sel = SEL_PC4;
    if (i_Jump) begin
      w_pc  = i_SumadorJump;
      w_sel = SEL_JUMP;
    end else if (i_JALR) begin
      w_pc  = i_rs;
      w_sel = SEL_JALR;
    end else if (i_pcSrc) begin
      w_pc  = i_SumadorBranch;
      w_sel = SEL_BRANCH;
    end
  end

  // Reset clears only the registered PC; the mux keeps running through reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc_q <= '0;
    end else if (i_enable) begin
      r_pc_q <= w_pc;
    end
  end

  assign o_pc   = w_pc;
  assign o_sel  = w_sel;
  assign o_pc_q = r_pc_q;

endmodule

// File: tb/tb_mux_pc.sv
// Directed bench for mux_pc: stimulus pushes expected {o_pc, o_sel, o_pc_q}
// into a queue and a monitor process pops and compares on each sample strobe.
module tb_mux_pc;

  localparam int NBITS = 32;
  localparam int EW    = 2 * NBITS + 2;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_Jump;
  logic             i_JALR;
  logic [NBITS-1:0] i_rs;
  logic             i_pcSrc;
  logic [NBITS-1:0] i_SumadorBranch;
  logic [NBITS-1:0] i_sumador_pc4;
  logic [NBITS-1:0] i_SumadorJump;
  logic             i_enable;
  logic [NBITS-1:0] o_pc;
  logic [NBITS-1:0] o_pc_q;
  logic [1:0]       o_sel;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            checks = 0;
  int            errors = 0;
  event          sample_ev;

  mux_pc #(.NBITS(NBITS)) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_Jump          (i_Jump),
    .i_JALR          (i_JALR),
    .i_rs            (i_rs),
    .i_pcSrc         (i_pcSrc),
    .i_SumadorBranch (i_SumadorBranch),
    .i_sumador_pc4   (i_sumador_pc4),
    .i_SumadorJump   (i_SumadorJump),
    .i_enable        (i_enable),
    .o_pc            (o_pc),
    .o_pc_q          (o_pc_q),
    .o_sel           (o_sel)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #50000;
    $display("FAIL watchdog: timeout reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  // scoreboard monitor
  always begin
    logic [EW-1:0] e;
    string         nm;
    @(sample_ev);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_underflow: sample strobe with empty expected queue");
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (o_pc !== e[EW-1 -: NBITS]) begin
        errors++;
        $display("FAIL %s.o_pc: got %h expected %h", nm, o_pc, e[EW-1 -: NBITS]);
      end
      checks++;
      if (o_sel !== e[NBITS+1 -: 2]) begin
        errors++;
        $display("FAIL %s.o_sel: got %0d expected %0d", nm, o_sel, e[NBITS+1 -: 2]);
      end
      checks++;
      if (o_pc_q !== e[NBITS-1:0]) begin
        errors++;
        $display("FAIL %s.o_pc_q: got %h expected %h", nm, o_pc_q, e[NBITS-1:0]);
      end
    end
  end

  // driver tasks
  task automatic drive(input logic jump, input logic jalr, input logic pcsrc,
                       input logic [NBITS-1:0] rs, input logic [NBITS-1:0] br,
                       input logic [NBITS-1:0] pc4, input logic [NBITS-1:0] jmp);
    i_Jump          = jump;
    i_JALR          = jalr;
    i_pcSrc         = pcsrc;
    i_rs            = rs;
    i_SumadorBranch = br;
    i_sumador_pc4   = pc4;
    i_SumadorJump   = jmp;
  endtask

  task automatic expect_now(input string nm, input logic [NBITS-1:0] pc,
                            input logic [1:0] sel, input logic [NBITS-1:0] pcq);
    exp_q.push_back({pc, sel, pcq});
    name_q.push_back(nm);
    ->sample_ev;
    #2;
  endtask

  task automatic vec(input string nm, input logic jump, input logic jalr, input logic pcsrc,
                     input logic [NBITS-1:0] rs, input logic [NBITS-1:0] br,
                     input logic [NBITS-1:0] pc4, input logic [NBITS-1:0] jmp,
                     input logic [NBITS-1:0] pc, input logic [1:0] sel,
                     input logic [NBITS-1:0] pcq);
    @(negedge i_clk);
    drive(jump, jalr, pcsrc, rs, br, pc4, jmp);
    expect_now(nm, pc, sel, pcq);
  endtask

  // stimulus
  initial begin
    logic [NBITS-1:0] xv;
    xv       = 'x;
    i_rst_n  = 1'b0;
    i_enable = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge i_clk);

    vec("mux_in_reset", 0, 0, 0, 32'h0, 32'h0, 32'h8, 32'h0, 32'h8, 2'd0, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    vec("pc4_default",  0, 0, 0, 32'h0, 32'h0, 32'h8, 32'h0, 32'h8, 2'd0, 32'h0);
    vec("jump",         1, 0, 0, 32'h0, 32'h0, 32'h8, 32'h4, 32'h4, 2'd3, 32'h0);
    vec("jump_dropped", 0, 0, 0, 32'h0, 32'h0, 32'h8, 32'h4, 32'h8, 2'd0, 32'h0);
    vec("jalr",         0, 1, 0, 32'h5, 32'h0, 32'h8, 32'h4, 32'h5, 2'd2, 32'h0);
    vec("jump_ov_jalr", 1, 1, 0, 32'h5, 32'h0, 32'h8, 32'h4, 32'h4, 2'd3, 32'h0);
    vec("branch",       0, 0, 1, 32'h5, 32'h4, 32'h8, 32'h0, 32'h4, 2'd1, 32'h0);
    vec("jalr_ov_br",   0, 1, 1, 32'h5, 32'h4, 32'h8, 32'h0, 32'h5, 2'd2, 32'h0);
    vec("all_selects",  1, 1, 1, 32'h5, 32'h6, 32'h8, 32'h7, 32'h7, 2'd3, 32'h0);
    vec("x_unselected", 1, 1, 1, xv, xv, xv, 32'hDEADBEEF, 32'hDEADBEEF, 2'd3, 32'h0);
    vec("x_unsel_br",   0, 0, 1, 32'h1, 32'hA5A5A5A5, xv, xv, 32'hA5A5A5A5, 2'd1, 32'h0);
    vec("full_width",   0, 0, 0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 2'd0, 32'h0);
    vec("unaligned",    0, 1, 0, 32'h80000003, 32'h0, 32'h8, 32'h0, 32'h80000003, 2'd2, 32'h0);
    vec("hold_disabled",0, 0, 0, 32'h0, 32'h0, 32'h100, 32'h0, 32'h100, 2'd0, 32'h0);

    // registered path
    i_enable = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    expect_now("load_100", 32'h100, 2'd0, 32'h100);
    i_enable = 1'b0;
    vec("stall_hold",   0, 0, 0, 32'h0, 32'h0, 32'h200, 32'h0, 32'h200, 2'd0, 32'h100);
    @(negedge i_clk);
    expect_now("stall_hold2", 32'h200, 2'd0, 32'h100);

    // async reset between edges, with an update pending
    i_enable = 1'b1;
    i_rst_n  = 1'b0;
    expect_now("async_reset", 32'h200, 2'd0, 32'h0);
    @(negedge i_clk);
    expect_now("reset_over_en", 32'h200, 2'd0, 32'h0);
    i_rst_n = 1'b1;
    expect_now("released", 32'h200, 2'd0, 32'h0);
    vec("jump_pending", 1, 0, 0, 32'h0, 32'h0, 32'h200, 32'h3C0, 32'h3C0, 2'd3, 32'h200);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_drain: %0d expected entries left, required 0", exp_q.size());
    end

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
